dma_axi_rd_burst: RTL and testbench
===================================

Name: dma_axi_rd_burst

Overview:
Read-only AXI4 burst master for the external-memory path. It converts one native Versat databus read request (address plus beat count) into a single AXI4 INCR read burst on the DDR/MIG port. Each returned beat is handed back to the requester with a one-cycle ready pulse. One instance sits downstream of each Versat read channel, between the databus and the AXI interconnect feeding the DDR controller.

Parameters:
ADDR_W, 32, byte address width (DDR_ADDR_W)
DATA_W, 256, data beat width in bits (MIG_BUS_W); power of two, at least 32
LEN_W, 8, AXI burst length field width; beats per burst = len+1, up to 256
AXI_ID, 0, constant value driven on m_axi_arid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
databus_valid  in  1  read request; held high for the whole transfer
databus_addr  in  ADDR_W  burst start byte address; DATA_W/8 aligned
dma_len  in  LEN_W  beats minus one
databus_rdata  out  DATA_W  returned beat; valid only while databus_ready=1
databus_ready  out  1  one-cycle pulse per returned beat
busy  out  1  high from request accept until return to IDLE
m_axi_arid  out  1  = AXI_ID
m_axi_araddr  out  ADDR_W  burst address
m_axi_arlen  out  8  burst length; zero-extended from dma_len
m_axi_arsize  out  3  constant log2(DATA_W/8)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arlock/arcache/arprot/arqos  out  1/4/3/4  constants 0/4'b0011/0/0
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rid  in  1  ignored
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  read valid
m_axi_rready  out  1  read ready
error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high and wins over every other event. Reset values: arvalid=0, rready=0, databus_ready=0, databus_rdata=0, busy=0, error=0, state=IDLE, beat counter=0. Reset during a burst abandons it; no recovery of outstanding R beats is attempted. The system resets the interconnect together with this block.
- State machine, four states:
  - IDLE: when databus_valid=1, latch addr and len into araddr/arlen, set arvalid=1 and busy=1, go to ADDR. Request-to-arvalid latency is 1 cycle.
  - ADDR: hold arvalid and araddr/arlen stable until arready=1. On arvalid&arready, drop arvalid, set rready=1, clear the beat counter, go to DATA. arvalid never drops before the handshake.
  - DATA: rready stays 1 (the native consumer cannot stall). Each rvalid&rready beat is registered: databus_rdata<=rdata and databus_ready<=1 for exactly one cycle, so R-to-native latency is 1 cycle. The counter increments per beat. On the beat where rlast=1 or counter==len: drop rready and go to DONE. Back-to-back beats give back-to-back ready pulses.
  - DONE: busy stays 1 until databus_valid=0 is seen, then busy=0 and go to IDLE. This keeps a still-held valid from being re-accepted as a new request.
- Counter width is LEN_W+1, so there is no wrap at len=255.
- Only one burst is outstanding; there is no AR pipelining.
- Requests must not cross a 4 KB boundary; the block does not split bursts.
- Changes to addr/len while busy=1 are ignored.

Optional Feature:
Macro DMA_RD_ERR_EN.
- Defined: error is set sticky, cleared only by reset, when any of these occurs:
  - an accepted R beat has rresp!=2'b00;
  - rlast=1 arrives before counter==len (early last); the FSM still terminates;
  - counter==len is reached with rlast=0 (missing last); the FSM still terminates;
  - an accepted request has addr[11:0] + (len+1)*DATA_W/8 > 4096 (checked in IDLE; the burst is still issued).
- Undefined: error is tied to 0 and none of the checking logic is built.

Test Plan:
- Single beat: addr=0x1000, len=0, arready held 1, one R beat 0xAB..AB with rlast=1 -> arvalid for 1 cycle with arlen=0; one databus_ready pulse the cycle after rvalid with rdata=0xAB..AB; busy drops the cycle after valid falls.
- Full burst: len=255, rvalid continuous -> 256 consecutive ready pulses, rdata matches an incrementing pattern, counter does not wrap, FSM ends in DONE.
- AR backpressure: arready low for 5 cycles -> arvalid, araddr and arlen stable for all 6 cycles; no rready before the handshake.
- R gaps: len=3, rvalid toggling 1,0,1,0... -> exactly 4 ready pulses, each aligned 1 cycle after an accepted beat; no pulse on idle cycles.
- Reset mid-burst: reset asserted in DATA after 2 of 8 beats -> next cycle all outputs at reset values, state IDLE; a new request afterwards completes normally.
- With DMA_RD_ERR_EN: rresp=2'b10 on beat 1 -> error=1 and held; early rlast at beat 2 of len=3 -> error=1 and FSM reaches DONE; addr=0xFF0, len=1 with DATA_W=256 -> error=1. Without the macro, the same cases leave error=0.

Source files
------------

// File: rtl/dma_axi_rd_burst_if.sv
// AXI4 read-only channel bundle (AR + R) between the DMA read burst master
// and the DDR-side interconnect. master = burst engine, slave = memory side.
interface dma_axi_rd_burst_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
);
   logic              arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic              arvalid;
   logic              arready;
   logic              rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      output arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      input  arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/dma_axi_rd_burst.sv
// Read-only AXI4 burst master: turns one databus read request (addr + beats-1)
// into a single INCR burst and returns each beat with a one-cycle ready pulse.
// Optional protocol/boundary error checking is built when DMA_RD_ERR_EN is
// defined; otherwise error_o is tied low.
module dma_axi_rd_burst #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int LEN_W  = 8,
   parameter int AXI_ID = 0
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 databus_valid_i,
   input  logic [ADDR_W-1:0]    databus_addr_i,
   input  logic [LEN_W-1:0]     dma_len_i,
   output logic [DATA_W-1:0]    databus_rdata_o,
   output logic                 databus_ready_o,
   output logic                 busy_o,
   output logic                 error_o,
   dma_axi_rd_burst_if.master   m_axi
);

   localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W/8));

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [LEN_W-1:0]    arlen_q, arlen_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                dready_q, dready_d;
   logic                busy_q, busy_d;
   // one extra bit so len=255 never wraps
   logic [LEN_W:0]      cnt_q, cnt_d;
   logic                beat, cnt_at_len, last_beat;
   logic                unused_ok;

   assign beat       = m_axi.rvalid && rready_q;
   assign cnt_at_len = (cnt_q == {1'b0, arlen_q});
   assign last_beat  = m_axi.rlast || cnt_at_len;

`ifdef DMA_RD_ERR_EN
   logic        error_q, error_d;
   logic [31:0] span;

   // end offset of the requested burst within its 4 KB page
   assign span = 32'(databus_addr_i[11:0])
               + (32'(dma_len_i) + 32'd1) * 32'(DATA_W/8);
   assign error_o   = error_q;
   assign unused_ok = m_axi.rid;
`else
   assign error_o   = 1'b0;
   assign unused_ok = ^{m_axi.rid, m_axi.rresp};
`endif

   // next-state and datapath updates for the burst FSM
   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rdata_d   = rdata_q;
      dready_d  = 1'b0;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
`ifdef DMA_RD_ERR_EN
      error_d   = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (databus_valid_i) begin
               araddr_d  = databus_addr_i;
               arlen_d   = dma_len_i;
               arvalid_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ADDR;
`ifdef DMA_RD_ERR_EN
               if (span > 32'd4096) error_d = 1'b1;
`endif
            end
         end
         ADDR: begin
            if (m_axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               rdata_d  = m_axi.rdata;
               dready_d = 1'b1;
               cnt_d    = cnt_q + 1'b1;
`ifdef DMA_RD_ERR_EN
               if (m_axi.rresp != 2'b00)        error_d = 1'b1;
               if (m_axi.rlast && !cnt_at_len)  error_d = 1'b1;
               if (cnt_at_len && !m_axi.rlast)  error_d = 1'b1;
`endif
               if (last_beat) begin
                  rready_d = 1'b0;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            // wait for the requester to drop valid so it is not re-accepted
            if (!databus_valid_i) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rdata_q   <= '0;
         dready_q  <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rdata_q   <= rdata_d;
         dready_q  <= dready_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef DMA_RD_ERR_EN
   // sticky error flag, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (reset_i) error_q <= 1'b0;
      else         error_q <= error_d;
   end
`endif

   assign m_axi.arid    = 1'(AXI_ID);
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arlen   = 8'(arlen_q);
   assign m_axi.arsize  = AR_SIZE;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = 4'b0011;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arqos   = 4'b0000;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

   assign databus_rdata_o = rdata_q;
   assign databus_ready_o = dready_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_dma_axi_rd_burst.sv
// Directed self-checking bench for dma_axi_rd_burst (DATA_W=256, LEN_W=8).
// Error expectations follow DMA_RD_ERR_EN as seen by this compile.
module tb_dma_axi_rd_burst;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 256;
   localparam int LEN_W  = 8;
`ifdef DMA_RD_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              dvalid;
   logic [ADDR_W-1:0] daddr;
   logic [LEN_W-1:0]  dlen;
   logic [DATA_W-1:0] drdata;
   logic              dready, busy, error;

   int n_cmp = 0;
   int n_err = 0;

   dma_axi_rd_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   dma_axi_rd_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .AXI_ID(0)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .databus_valid_i (dvalid),
      .databus_addr_i  (daddr),
      .dma_len_i       (dlen),
      .databus_rdata_o (drdata),
      .databus_ready_o (dready),
      .busy_o          (busy),
      .error_o         (error),
      .m_axi           (axi)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      dvalid = 1'b0; daddr = '0; dlen = '0;
      axi.arready = 1'b0; axi.rid = 1'b0; axi.rdata = '0;
      axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   // present a request and let the DUT take it (returns after the accept edge)
   task automatic issue(input logic [31:0] a, input logic [7:0] l);
      dvalid = 1'b1; daddr = a; dlen = l;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++;
      if ({axi.arvalid, axi.rready, dready, busy, error} !== 5'b0 || drdata !== '0) begin
         n_err++;
         $display("FAIL reset_vals: got arv=%b rr=%b drdy=%b busy=%b err=%b rdata=%h want all 0",
                  axi.arvalid, axi.rready, dready, busy, error, drdata);
      end
      n_cmp++;
      if ({axi.arburst, axi.arsize, axi.arcache, axi.arlock, axi.arprot, axi.arqos, axi.arid}
          !== {2'b01, 3'd5, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0}) begin
         n_err++;
         $display("FAIL ar_consts: got burst=%b size=%0d cache=%b want 01/5/0011", axi.arburst, axi.arsize, axi.arcache);
      end
   endtask

   task automatic test_single;
      logic [255:0] pat;
      pat = {32{8'hAB}};
      do_reset();
      axi.arready = 1'b1;
      issue(32'h1000, 8'd0);
      n_cmp++;
      if ({axi.arvalid, axi.rready, busy} !== 3'b101 || axi.araddr !== 32'h1000 || axi.arlen !== 8'd0) begin
         n_err++;
         $display("FAIL single_ar: got arv=%b rr=%b busy=%b addr=%h len=%0d want 1/0/1 1000 0",
                  axi.arvalid, axi.rready, busy, axi.araddr, axi.arlen);
      end
      tick();
      n_cmp++;
      if ({axi.arvalid, axi.rready} !== 2'b01) begin
         n_err++;
         $display("FAIL single_hs: got arv=%b rr=%b want 0 1", axi.arvalid, axi.rready);
      end
      axi.rvalid = 1'b1; axi.rdata = pat; axi.rlast = 1'b1;
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      n_cmp++;
      if (dready !== 1'b1 || drdata !== pat || axi.rready !== 1'b0) begin
         n_err++;
         $display("FAIL single_beat: got drdy=%b rr=%b rdata=%h want 1 0 %h", dready, axi.rready, drdata, pat);
      end
      tick();
      n_cmp++;
      if ({dready, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL single_done: got drdy=%b busy=%b want 0 1", dready, busy);
      end
      dvalid = 1'b0;
      tick();
      n_cmp++;
      if ({busy, error} !== 2'b00) begin
         n_err++;
         $display("FAIL single_idle: got busy=%b err=%b want 0 0", busy, error);
      end
   endtask

   task automatic test_full_burst;
      logic [255:0] pat;
      do_reset();
      axi.arready = 1'b1;
      issue(32'h0, 8'd255);
      n_cmp++;
      if (axi.arlen !== 8'd255) begin
         n_err++;
         $display("FAIL full_arlen: got %0d want 255", axi.arlen);
      end
      tick();
      for (int i = 0; i < 256; i++) begin
         pat = {8{32'(i) + 32'h0100_0000}};
         axi.rvalid = 1'b1; axi.rdata = pat; axi.rlast = (i == 255);
         tick();
         n_cmp++;
         if (dready !== 1'b1 || drdata !== pat || axi.rready !== (i != 255)) begin
            n_err++;
            $display("FAIL full_beat%0d: got drdy=%b rr=%b rdata=%h want 1 %b %h",
                     i, dready, axi.rready, drdata[31:0], (i != 255), pat[31:0]);
         end
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      tick();
      n_cmp++;
      if ({dready, axi.rready, busy} !== 3'b001) begin
         n_err++;
         $display("FAIL full_done: got drdy=%b rr=%b busy=%b want 0 0 1", dready, axi.rready, busy);
      end
      // 0x000 + 256*32 bytes spills past the 4 KB page
      n_cmp++;
      if (error !== ERR_EN) begin
         n_err++;
         $display("FAIL full_err: got %b want %b", error, ERR_EN);
      end
      dvalid = 1'b0;
      tick();
   endtask

   task automatic test_ar_backpressure;
      do_reset();
      issue(32'h2040, 8'd3);
      daddr = 32'hDEAD_0000; dlen = 8'd9;   // must be ignored while busy
      for (int c = 0; c < 6; c++) begin
         n_cmp++;
         if ({axi.arvalid, axi.rready} !== 2'b10 || axi.araddr !== 32'h2040 || axi.arlen !== 8'd3) begin
            n_err++;
            $display("FAIL ar_hold%0d: got arv=%b rr=%b addr=%h len=%0d want 1 0 2040 3",
                     c, axi.arvalid, axi.rready, axi.araddr, axi.arlen);
         end
         if (c < 5) tick();
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      n_cmp++;
      if ({axi.arvalid, axi.rready} !== 2'b01) begin
         n_err++;
         $display("FAIL ar_hs: got arv=%b rr=%b want 0 1", axi.arvalid, axi.rready);
      end
      for (int i = 0; i < 4; i++) begin
         axi.rvalid = 1'b1; axi.rdata = 256'(i); axi.rlast = (i == 3);
         tick();
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      n_cmp++;
      if ({axi.rready, busy, error} !== 3'b010 || drdata !== 256'd3) begin
         n_err++;
         $display("FAIL ar_end: got rr=%b busy=%b err=%b rdata=%0h want 0 1 0 3", axi.rready, busy, error, drdata);
      end
      dvalid = 1'b0;
      tick();
   endtask

   task automatic test_r_gaps;
      int pulses, beatn;
      logic exp;
      do_reset();
      axi.arready = 1'b1;
      issue(32'h3000, 8'd3);
      tick();
      pulses = 0; beatn = 0;
      for (int k = 0; k < 8; k++) begin
         exp = (k % 2 == 0);
         axi.rvalid = exp; axi.rdata = 256'(32'hC0 + beatn); axi.rlast = exp && (beatn == 3);
         tick();
         if (dready === 1'b1) pulses++;
         n_cmp++;
         if (dready !== exp || (exp && drdata !== 256'(32'hC0 + beatn))) begin
            n_err++;
            $display("FAIL gap_cyc%0d: got drdy=%b rdata=%0h want %b %0h", k, dready, drdata, exp, 32'hC0 + beatn);
         end
         if (exp) beatn++;
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      n_cmp++;
      if (pulses !== 4 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL gap_count: got pulses=%0d busy=%b want 4 1", pulses, busy);
      end
      dvalid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      axi.arready = 1'b1;
      issue(32'h4000, 8'd7);
      tick();
      axi.rvalid = 1'b1; axi.rdata = {32{8'h11}};
      tick();
      axi.rdata = {32{8'h22}};
      tick();
      axi.rdata = {32{8'h33}};
      reset = 1'b1; dvalid = 1'b0;
      tick();
      reset = 1'b0; axi.rvalid = 1'b0;
      n_cmp++;
      if ({axi.arvalid, axi.rready, dready, busy, error} !== 5'b0 || drdata !== '0) begin
         n_err++;
         $display("FAIL rst_mid: got arv=%b rr=%b drdy=%b busy=%b err=%b rdata=%h want all 0",
                  axi.arvalid, axi.rready, dready, busy, error, drdata[31:0]);
      end
      issue(32'h5000, 8'd0);
      n_cmp++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h5000 || axi.arlen !== 8'd0) begin
         n_err++;
         $display("FAIL rst_new_ar: got arv=%b addr=%h len=%0d want 1 5000 0", axi.arvalid, axi.araddr, axi.arlen);
      end
      tick();
      axi.rvalid = 1'b1; axi.rdata = {32{8'h5A}}; axi.rlast = 1'b1;
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      n_cmp++;
      if (dready !== 1'b1 || drdata !== {32{8'h5A}}) begin
         n_err++;
         $display("FAIL rst_new_beat: got drdy=%b rdata=%h want 1 5a..", dready, drdata[31:0]);
      end
      dvalid = 1'b0;
      tick(); tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_new_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_err_rresp;
      do_reset();
      axi.arready = 1'b1;
      issue(32'h6000, 8'd3);
      tick();
      for (int i = 0; i < 4; i++) begin
         axi.rvalid = 1'b1; axi.rdata = 256'(i); axi.rlast = (i == 3);
         axi.rresp = (i == 1) ? 2'b10 : 2'b00;
         tick();
         if (i == 0) begin
            n_cmp++;
            if (error !== 1'b0) begin
               n_err++;
               $display("FAIL rresp_pre: got %b want 0", error);
            end
         end
         if (i == 1) begin
            n_cmp++;
            if (error !== ERR_EN) begin
               n_err++;
               $display("FAIL rresp_set: got %b want %b", error, ERR_EN);
            end
         end
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      dvalid = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({busy, error} !== {1'b0, ERR_EN}) begin
         n_err++;
         $display("FAIL rresp_sticky: got busy=%b err=%b want 0 %b", busy, error, ERR_EN);
      end
   endtask

   task automatic test_err_early_last;
      do_reset();
      axi.arready = 1'b1;
      issue(32'h7000, 8'd3);
      tick();
      for (int i = 0; i < 3; i++) begin
         axi.rvalid = 1'b1; axi.rdata = 256'(i); axi.rlast = (i == 2);
         tick();
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      n_cmp++;
      if ({axi.rready, dready, error} !== {2'b01, ERR_EN}) begin
         n_err++;
         $display("FAIL early_last: got rr=%b drdy=%b err=%b want 0 1 %b", axi.rready, dready, error, ERR_EN);
      end
      tick();
      n_cmp++;
      if ({dready, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL early_done: got drdy=%b busy=%b want 0 1", dready, busy);
      end
      dvalid = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL early_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_err_4k;
      // 0xFC0 + 2*32 = 0x1000 ends exactly on the page edge: legal
      do_reset();
      axi.arready = 1'b1;
      issue(32'hFC0, 8'd1);
      n_cmp++;
      if (error !== 1'b0) begin
         n_err++;
         $display("FAIL edge_4k: got %b want 0", error);
      end
      dvalid = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         axi.rvalid = 1'b1; axi.rlast = (i == 1);
         tick();
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      tick();
      // 0xFF0 + 64 crosses into the next page
      issue(32'hFF0, 8'd1);
      n_cmp++;
      if ({axi.arvalid, error} !== {1'b1, ERR_EN}) begin
         n_err++;
         $display("FAIL cross_4k: got arv=%b err=%b want 1 %b", axi.arvalid, error, ERR_EN);
      end
      dvalid = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         axi.rvalid = 1'b1; axi.rlast = (i == 1);
         tick();
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      tick();
      n_cmp++;
      if ({busy, error} !== {1'b0, ERR_EN}) begin
         n_err++;
         $display("FAIL cross_end: got busy=%b err=%b want 0 %b", busy, error, ERR_EN);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_full_burst();
      test_ar_backpressure();
      test_r_gaps();
      test_reset_mid_burst();
      test_err_rresp();
      test_err_early_last();
      test_err_4k();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
